f32_wrfifo_ctrl: RTL

Sequencing controller for one (half, bank) lane of the f32 write FIFO array. It tracks occupancy of the WFFOCNT-entry shift FIFO and accepts one write per cycle, appended at the tail. It retires 0–2 entries per cycle from the head. Each cycle it drives the per-entry one-hot mux select and shift distance that the data array registers on the next clock edge. One instance sits beside each of the 2×NUMVBNK FIFO lanes.

---
 rtl/f32_wrfifo_ctrl.sv | 58 +++++
 1 files changed

// File: rtl/f32_wrfifo_ctrl.sv
// f32_wrfifo_ctrl: occupancy and shift/load select sequencing for one f32 write FIFO lane (optional F32_WRFIFO_ERRCHK_EN adds sticky fifo_err)
module f32_wrfifo_ctrl #(
  parameter int WFFOCNT = 16,
  parameter int CNTW    = 5
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            push_vld,
  output logic            push_rdy,
  input  logic [1:0]      pop_cnt,
  output logic [2:0]      wrfifo_new_dat_sel [0:WFFOCNT-1],
  output logic [3:0]      wrfifo_dcnt [0:WFFOCNT-1],
  output logic [CNTW-1:0] fifo_cnt,
`ifdef F32_WRFIFO_ERRCHK_EN
  output logic            fifo_err,
`endif
  output logic [1:0]      head_vld
);
  logic [CNTW-1:0] r_cnt;
  logic [1:0]      w_pc;
  logic [1:0]      w_eff;
  logic [CNTW-1:0] w_tail;
  logic            w_push;
  assign w_pc     = (pop_cnt == 2'd3) ? 2'd2 : pop_cnt;
  assign w_eff    = (CNTW'(w_pc) > r_cnt) ? r_cnt[1:0] : w_pc;
  assign w_tail   = r_cnt - CNTW'(w_eff);
  assign push_rdy = !rst && (w_tail < CNTW'(WFFOCNT));
  assign w_push   = push_vld && push_rdy;
  assign fifo_cnt = r_cnt;
  assign head_vld = {r_cnt > CNTW'(1), r_cnt != '0};
  // Per-entry select: surviving entries shift toward the head, the tail slot loads, the rest hold
  always_comb begin
    for (int i = 0; i < WFFOCNT; i++) begin
      wrfifo_new_dat_sel[i] = 3'b100;
      wrfifo_dcnt[i]        = '0;
      if (!rst && CNTW'(i) < w_tail && w_eff != 2'd0) begin
        wrfifo_new_dat_sel[i] = 3'b010;
        wrfifo_dcnt[i]        = 4'(w_eff);
      end else if (CNTW'(i) == w_tail && w_push) begin
        wrfifo_new_dat_sel[i] = 3'b001;
      end
    end
  end
  // Occupancy tracks the array contents, updating on the same edge that captures the selects
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_cnt <= '0;
    else     r_cnt <= w_tail + CNTW'(w_push);
  end
`ifdef F32_WRFIFO_ERRCHK_EN
  logic r_err;
  assign fifo_err = r_err;
  // Sticky flag for over-pop, pop_cnt of 3, or a push while not ready; cleared only by reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_err <= 1'b0;
    else     r_err <= r_err | (CNTW'(pop_cnt) > r_cnt) | (pop_cnt == 2'd3) | (push_vld && !push_rdy);
  end
`endif
endmodule
